// File: rtl/mem_responder_if.sv
// Load/store request bus between the core and the data-memory responder.
// The err signal exists only when MEM_RESPONDER_RANGE_CHECK_EN is defined.
interface mem_responder_if #(
  parameter int ADDR_W = 18
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              busy;
  logic              ack;
  logic [31:0]       rdata;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  logic              err;

  modport master (output req, we, addr, wdata, be, input busy, ack, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output busy, ack, rdata, err);
`else
  modport master (output req, we, addr, wdata, be, input busy, ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output busy, ack, rdata);
`endif
endinterface

// File: rtl/mem_responder.sv
// Wait-state data-memory responder: IDLE -> WAIT -> RESP, access on the RESP-entry edge.
// Optional MEM_RESPONDER_RANGE_CHECK_EN flags and suppresses out-of-range accesses via err.
module mem_responder #(
  parameter int ADDR_W      = 18,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             we_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             oor_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       be_reg;
  logic [31:0]      rdata_reg;
  logic             err_reg;

  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             do_access;
  logic             in_oor;
  logic             acc_we;
  logic             acc_oor;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign in_oor = (bus.addr >> IDX_W) != '0;
`else
  assign in_oor = 1'b0;
`endif

  assign accept    = (state_reg == IDLE) && bus.req;
  assign do_access = (accept && (WAIT_CYCLES == 0)) || ((state_reg == WAIT) && (cnt_reg == 4'd0));

  // With zero wait states the access happens on the accept edge, so use the live bus.
  always_comb begin
    if (state_reg == IDLE) begin
      acc_we    = bus.we;
      acc_idx   = bus.addr[IDX_W-1:0];
      acc_oor   = in_oor;
      acc_wdata = bus.wdata;
      acc_be    = bus.be;
    end else begin
      acc_we    = we_reg;
      acc_idx   = idx_reg;
      acc_oor   = oor_reg;
      acc_wdata = wdata_reg;
      acc_be    = be_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_reg != IDLE);
    bus.ack   = (state_reg == RESP);
    bus.rdata = rdata_reg;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    bus.err   = (state_reg == RESP) && err_reg;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      oor_reg   <= 1'b0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg    <= bus.we;
        idx_reg   <= bus.addr[IDX_W-1:0];
        oor_reg   <= in_oor;
        wdata_reg <= bus.wdata;
        be_reg    <= bus.be;
      end
      if (do_access) begin
        err_reg <= acc_oor;
        if (!acc_we) rdata_reg <= acc_oor ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // rst_n gates the write so an access aborted by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && acc_we && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand sequences, random traffic vs a word-array model.
module tb_mem_responder;
  localparam int ADDR_W = 18;
  localparam int DEPTH  = 1024;
  localparam int WAITC  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W)) bus ();
  mem_responder_if #(.ADDR_W(ADDR_W)) bus0 ();

  mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  int total = 0;
  int bad = 0;

  logic [31:0] ref_mem   [DEPTH];
  logic [3:0]  ref_known [DEPTH];
  logic [31:0] ref_rdata;
  logic [31:0] ref_rmask;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_oor(input logic [ADDR_W-1:0] a);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // One full transaction on the WAIT_CYCLES=2 instance; ends in the first idle cycle after ack.
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit use_exp, input logic [31:0] exp_rd);
    int          idx;
    bit          oor;
    logic [31:0] exp_word;
    logic [31:0] kmask;
    logic [31:0] wmask;
    idx = int'(addr) % DEPTH;
    oor = ref_oor(addr);
    if (oor) begin
      exp_word = 32'd0;
      kmask    = 32'hFFFF_FFFF;
    end else begin
      exp_word = ref_mem[idx];
      kmask    = lane_mask(ref_known[idx]);
    end
    if (use_exp) begin
      exp_word = exp_rd;
      kmask    = 32'hFFFF_FFFF;
    end
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.be = be;
    @(posedge clk); #1;
    // Scramble the bus after accept; only captured values may matter.
    bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = ADDR_W'($urandom);
    bus.wdata = $urandom; bus.be = 4'($urandom);
    for (int c = 1; c <= WAITC + 1; c++) begin
      chk("busy_active", 32'(bus.busy), 32'd1);
      chk("ack_timing", 32'(bus.ack), 32'(c == WAITC + 1));
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
      chk("err", 32'(bus.err), 32'((c == WAITC + 1) && oor));
`endif
      if (c == WAITC + 1 && !we) chk("rdata_read", bus.rdata & kmask, exp_word & kmask);
      else chk("rdata_held", bus.rdata & ref_rmask, ref_rdata & ref_rmask);
      if (c < WAITC + 1) begin
        @(posedge clk); #1;
      end
    end
    if (we && !oor) begin
      wmask = lane_mask(be);
      ref_mem[idx]   = (ref_mem[idx] & ~wmask) | (wdata & wmask);
      ref_known[idx] = ref_known[idx] | be;
    end else if (!we) begin
      ref_rdata = exp_word;
      ref_rmask = kmask;
    end
    $display("txn we=%0d addr=%h wdata=%h be=%h rdata=%h", we, addr, wdata, be, bus.rdata);
    @(posedge clk); #1;
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("ack_idle", 32'(bus.ack), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'd0;
      ref_known[i] = 4'd0;
    end
    ref_rdata = 32'd0;
    ref_rmask = 32'hFFFF_FFFF;
    bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = 32'd0;  bus.be = 4'd0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = 32'd0; bus0.be = 4'd0;

    vecs[0]  = '{1'b1, 18'd5,    32'hCAFE_BABE, 4'hF, 32'd0};
    vecs[1]  = '{1'b0, 18'd5,    32'd0,         4'hF, 32'hCAFE_BABE};
    vecs[2]  = '{1'b1, 18'd5,    32'h1122_3344, 4'h5, 32'd0};
    vecs[3]  = '{1'b0, 18'd5,    32'd0,         4'hF, 32'hCA22_BA44};
    vecs[4]  = '{1'b1, 18'd3,    32'h1111_1111, 4'hF, 32'd0};
    vecs[5]  = '{1'b1, 18'd1027, 32'h0000_0005, 4'hF, 32'd0};
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    vecs[6]  = '{1'b0, 18'd3,    32'd0,         4'hF, 32'h1111_1111};
    vecs[7]  = '{1'b0, 18'd1027, 32'd0,         4'hF, 32'h0000_0000};
`else
    vecs[6]  = '{1'b0, 18'd3,    32'd0,         4'hF, 32'h0000_0005};
    vecs[7]  = '{1'b0, 18'd1027, 32'd0,         4'hF, 32'h0000_0005};
`endif
    vecs[8]  = '{1'b1, 18'd9,    32'hDEAD_BEEF, 4'hF, 32'd0};
    vecs[9]  = '{1'b1, 18'd9,    32'hFFFF_FFFF, 4'h0, 32'd0};
    vecs[10] = '{1'b0, 18'd9,    32'd0,         4'hF, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 18'd7,    32'hAAAA_AAAA, 4'hF, 32'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 12; v++)
      run_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, !vecs[v].we, vecs[v].exp);

    // Reset in the WAIT state of a write to 7: the write must be abandoned.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 18'd7; bus.wdata = 32'hBBBB_BBBB; bus.be = 4'hF;
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ack", 32'(bus.ack), 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_rdata = 32'd0;
    ref_rmask = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_ack", 32'(bus.ack), 32'd0);
    end
    run_txn(1'b0, 18'd7, 32'd0, 4'hF, 1'b1, 32'hAAAA_AAAA);

    // Zero-wait instance: seed words 1..3, then hold req high across three reads.
    for (int a = 1; a <= 3; a++) begin
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = ADDR_W'(a);
      bus0.wdata = 32'h100 + 32'(a); bus0.be = 4'hF;
      @(posedge clk); #1;
      bus0.req = 1'b0;
      chk("w0_ack", 32'(bus0.ack), 32'd1);
      @(posedge clk); #1;
      chk("w0_ack_off", 32'(bus0.ack), 32'd0);
    end
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 18'd1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk("w0_hold_ack", 32'(bus0.ack), 32'(k % 2 == 1 && k <= 5));
      chk("w0_hold_busy", 32'(bus0.busy), 32'(k % 2 == 1 && k <= 5));
      if (k % 2 == 1 && k <= 5) chk("w0_hold_rdata", bus0.rdata, 32'h100 + 32'((k + 1) / 2));
      bus0.addr = ADDR_W'(1 + (k + 1) / 2);
      if (k >= 5) bus0.req = 1'b0;
    end

    // Random traffic on a small window plus aliased addresses.
    for (int n = 0; n < 60; n++) begin
      logic [ADDR_W-1:0] ra;
      ra = ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra = ra + ADDR_W'(DEPTH * $urandom_range(1, 3));
      run_txn(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
